// File: rtl/knn_ctrl.sv
// knn_ctrl: sequencer for a k-nearest-neighbour classifier.
// It holds the query on the comparison systole for LAT cycles, captures the
// K_NUM sorted neighbours, runs a K_NUM-cycle majority vote over their labels
// (ties go to the nearer neighbour) and publishes the winning label, its vote
// count and the nearest distance with a one-cycle done pulse.
module knn_ctrl #(
    parameter int SUM_LEN = 10,
    parameter int LBL_LEN = 10,
    parameter int K_NUM   = 5,
    parameter int LAT     = 20
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              abort,
    input  logic [K_NUM-1:0][SUM_LEN-1:0]     sys_outS,
    input  logic [K_NUM-1:0][LBL_LEN-1:0]     sys_outL,
    output logic                              sys_sel,
    output logic                              busy,
    output logic                              done,
    output logic [LBL_LEN-1:0]                result_lbl,
    output logic [$clog2(K_NUM+1)-1:0]        result_cnt,
    output logic [SUM_LEN-1:0]                result_dist
);

    localparam int CNT_W  = $clog2(K_NUM + 1);
    localparam int WAIT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int IDX_W  = (K_NUM > 1) ? $clog2(K_NUM) : 1;

    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(LAT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(K_NUM - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        VOTE = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                          state;
    logic [WAIT_W-1:0]               wait_cnt;
    logic [IDX_W-1:0]                idx;
    logic [CNT_W-1:0]                best_cnt;
    logic [LBL_LEN-1:0]              best_lbl;
    logic [K_NUM-1:0][SUM_LEN-1:0]   cap_sum;
    logic [K_NUM-1:0][LBL_LEN-1:0]   cap_lbl;

    logic [CNT_W-1:0]                vote_cnt;
    logic                            vote_win;
    logic [CNT_W-1:0]                nxt_cnt;
    logic [LBL_LEN-1:0]              nxt_lbl;

    // Only the nearest captured sum drives an output; the remaining captured
    // sums are kept so the whole neighbour set is frozen together.
    logic unused_cap_sum;
    assign unused_cap_sum = ^cap_sum;

    // Count how many captured labels match the candidate at idx and decide
    // whether it strictly beats the best so far (equal counts keep the nearer).
    always_comb begin
        vote_cnt = '0;
        for (int j = 0; j < K_NUM; j++) begin
            if (cap_lbl[j] == cap_lbl[idx]) begin
                vote_cnt = vote_cnt + CNT_W'(1);
            end
        end
        vote_win = (vote_cnt > best_cnt);
        nxt_cnt  = vote_win ? vote_cnt     : best_cnt;
        nxt_lbl  = vote_win ? cap_lbl[idx] : best_lbl;
    end

    // Control FSM with registered outputs; abort overrides every state and
    // leaves the published result untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            idx         <= '0;
            best_cnt    <= '0;
            best_lbl    <= '0;
            cap_sum     <= '0;
            cap_lbl     <= '0;
            sys_sel     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result_lbl  <= '0;
            result_cnt  <= '0;
            result_dist <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state   <= IDLE;
                sys_sel <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_LOAD;
                            sys_sel  <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end
                    WAIT: begin
                        if (wait_cnt == '0) begin
                            cap_sum  <= sys_outS;
                            cap_lbl  <= sys_outL;
                            idx      <= '0;
                            best_cnt <= '0;
                            best_lbl <= '0;
                            sys_sel  <= 1'b0;
                            state    <= VOTE;
                        end else begin
                            wait_cnt <= wait_cnt - WAIT_W'(1);
                        end
                    end
                    VOTE: begin
                        best_cnt <= nxt_cnt;
                        best_lbl <= nxt_lbl;
                        if (idx == IDX_LAST) begin
                            // Publish together with done so the result is
                            // visible in the same cycle as the pulse.
                            state       <= DONE;
                            done        <= 1'b1;
                            result_lbl  <= nxt_lbl;
                            result_cnt  <= nxt_cnt;
                            result_dist <= cap_sum[0];
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state   <= IDLE;
                        sys_sel <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_knn_ctrl.sv
// tb_knn_ctrl: randomized and directed checks of knn_ctrl against a
// histogram-based majority-vote model, for LAT=20 and LAT=1 instances.
module tb_knn_ctrl;

    localparam int SW = 10;
    localparam int LW = 10;
    localparam int K  = 5;
    localparam int LT = 20;
    localparam int CW = $clog2(K + 1);

    logic clk;
    logic rst;
    logic start, abort;
    logic start1, abort1;
    logic [K-1:0][SW-1:0] sys_outS;
    logic [K-1:0][LW-1:0] sys_outL;

    logic          sys_sel, busy, done;
    logic [LW-1:0] result_lbl;
    logic [CW-1:0] result_cnt;
    logic [SW-1:0] result_dist;

    logic          sys_sel1, busy1, done1;
    logic [LW-1:0] result_lbl1;
    logic [CW-1:0] result_cnt1;
    logic [SW-1:0] result_dist1;

    int n_vec = 0;
    int n_err = 0;
    int lb[K];
    int sm[K];

    knn_ctrl #(.SUM_LEN(SW), .LBL_LEN(LW), .K_NUM(K), .LAT(LT)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .sys_outS(sys_outS), .sys_outL(sys_outL),
        .sys_sel(sys_sel), .busy(busy), .done(done),
        .result_lbl(result_lbl), .result_cnt(result_cnt), .result_dist(result_dist)
    );

    knn_ctrl #(.SUM_LEN(SW), .LBL_LEN(LW), .K_NUM(K), .LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .sys_outS(sys_outS), .sys_outL(sys_outL),
        .sys_sel(sys_sel1), .busy(busy1), .done(done1),
        .result_lbl(result_lbl1), .result_cnt(result_cnt1), .result_dist(result_dist1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Majority vote from a label histogram; among equal counts the label
    // appearing first (nearest) wins.
    function automatic void model(output int wl, output int wc);
        int hist[int];
        wl = 0;
        wc = 0;
        for (int i = 0; i < K; i++)
            hist[lb[i]] = hist.exists(lb[i]) ? hist[lb[i]] + 1 : 1;
        for (int i = 0; i < K; i++)
            if (hist[lb[i]] > wc) begin
                wc = hist[lb[i]];
                wl = lb[i];
            end
    endfunction

    task automatic drive_sys();
        for (int i = 0; i < K; i++) begin
            sys_outS[i] = SW'(sm[i]);
            sys_outL[i] = LW'(lb[i]);
        end
    endtask

    task automatic rand_query(input int lmax);
        sm[0] = int'($urandom_range(0, 50));
        for (int i = 0; i < K; i++) begin
            lb[i] = int'($urandom_range(0, lmax));
            if (i > 0) sm[i] = sm[i-1] + int'($urandom_range(0, 100));
        end
    endtask

    // One full transaction on the LAT=20 instance. Also releases rst on the
    // start cycle, and optionally pulses start during WAIT and during DONE.
    task automatic run_txn(input string tag, input bit poke);
        int wl, wc, done_at, dones, sel_cycles, b_first, b_end;
        model(wl, wc);
        done_at = -1; dones = 0; sel_cycles = 0; b_first = 0; b_end = 1;
        @(negedge clk);
        drive_sys();
        rst = 1'b0;
        start = 1'b1;
        for (int k = 1; k <= LT + K + 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (sys_sel) sel_cycles++;
            if (done) begin
                dones++;
                if (done_at < 0) done_at = k;
            end
            if (k == 1) b_first = int'(busy);
            if (k == LT + K + 2) b_end = int'(busy);
            if (k == LT + 1) begin
                sys_outS = {K{SW'($urandom)}};
                sys_outL = {K{LW'($urandom)}};
            end
            if (poke && (k == 3 || k == LT + K + 1)) start = 1'b1;
        end
        chk({tag, "_done_at"}, done_at, LT + K + 1);
        chk({tag, "_dones"}, dones, 1);
        chk({tag, "_sel_cycles"}, sel_cycles, LT);
        chk({tag, "_busy_start"}, b_first, 1);
        chk({tag, "_busy_end"}, b_end, 0);
        chk({tag, "_lbl"}, int'(result_lbl), wl);
        chk({tag, "_cnt"}, int'(result_cnt), wc);
        chk({tag, "_dist"}, int'(result_dist), sm[0]);
    endtask

    // One transaction on the LAT=1 instance.
    task automatic run_lat1(input string tag);
        int wl, wc, done_at, dones, sel_cycles;
        model(wl, wc);
        done_at = -1; dones = 0; sel_cycles = 0;
        @(negedge clk);
        drive_sys();
        start1 = 1'b1;
        for (int k = 1; k <= K + 5; k++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (sys_sel1) sel_cycles++;
            if (done1) begin
                dones++;
                if (done_at < 0) done_at = k;
            end
        end
        chk({tag, "_done_at"}, done_at, K + 2);
        chk({tag, "_dones"}, dones, 1);
        chk({tag, "_sel_cycles"}, sel_cycles, 1);
        chk({tag, "_busy_end"}, int'(busy1), 0);
        chk({tag, "_lbl"}, int'(result_lbl1), wl);
        chk({tag, "_cnt"}, int'(result_cnt1), wc);
        chk({tag, "_dist"}, int'(result_dist1), sm[0]);
    endtask

    initial begin
        int dones;
        rst = 1'b1;
        start = 1'b0; abort = 1'b0;
        start1 = 1'b0; abort1 = 1'b0;
        sys_outS = '0; sys_outL = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sel", int'(sys_sel), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_lbl", int'(result_lbl), 0);
        chk("rst_cnt", int'(result_cnt), 0);
        chk("rst_dist", int'(result_dist), 0);

        // Directed example; rst is released on the start cycle itself
        lb = '{3, 7, 3, 7, 9};
        sm = '{4, 6, 8, 9, 12};
        run_txn("ex1", 1'b0);
        chk("ex1_lbl_const", int'(result_lbl), 3);
        chk("ex1_cnt_const", int'(result_cnt), 2);
        chk("ex1_dist_const", int'(result_dist), 4);

        // Abort in WAIT: drops busy, no done, previous result held
        lb = '{5, 5, 5, 5, 5};
        sm = '{20, 21, 22, 23, 24};
        @(negedge clk);
        drive_sys();
        start = 1'b1;
        dones = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_sel", int'(sys_sel), 0);
        for (int k = 0; k < LT + K + 4; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("abort_dones", dones, 0);
        chk("abort_lbl_held", int'(result_lbl), 3);
        chk("abort_cnt_held", int'(result_cnt), 2);
        chk("abort_dist_held", int'(result_dist), 4);

        // Unanimous labels, with start pokes during WAIT and DONE
        run_txn("same", 1'b1);
        chk("same_cnt_const", int'(result_cnt), 5);

        // abort and start together in IDLE: stays idle
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("abst_busy", int'(busy), 0);
        chk("abst_sel", int'(sys_sel), 0);

        // Reset in VOTE: everything clears at once and no done appears
        lb = '{9, 9, 2, 2, 2};
        @(negedge clk);
        drive_sys();
        start = 1'b1;
        for (int k = 1; k <= LT + 3; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk("vrst_busy", int'(busy), 0);
        chk("vrst_done", int'(done), 0);
        chk("vrst_sel", int'(sys_sel), 0);
        chk("vrst_lbl", int'(result_lbl), 0);
        chk("vrst_cnt", int'(result_cnt), 0);
        chk("vrst_dist", int'(result_dist), 0);
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("vrst_dones", dones, 0);

        // Distinct labels right after reset release: nearest wins the tie
        lb = '{1, 2, 3, 4, 6};
        sm = '{7, 30, 31, 90, 200};
        run_txn("dist", 1'b0);
        chk("dist_lbl_const", int'(result_lbl), 1);

        // LAT=1 instance
        lb = '{3, 7, 3, 7, 9};
        sm = '{4, 6, 8, 9, 12};
        run_lat1("lat1_ex");
        for (int n = 0; n < 3; n++) begin
            rand_query(2);
            run_lat1("lat1_rnd");
        end

        // Randomized transactions, narrow and wide label ranges
        for (int n = 0; n < 8; n++) begin
            rand_query((n % 2 == 0) ? 3 : 1023);
            run_txn("rnd", n[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
